// File: rtl/s2p.sv
`default_nettype none
// ============================================================================
// Module   : s2p
// Brief    : Serial-to-parallel deserializer, LSB first, with a one-word
//            output holding register on a valid/ready parallel interface.
// Revision : 1.0 - initial release
// ============================================================================
module s2p #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         s_valid,
    input  logic         s_data,
    output logic         s_ready,
    output logic [N-1:0] p_data,
    output logic         p_valid,
    input  logic         p_ready,
    output logic         busy
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        STALL   = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [N-1:0]   shift_reg_q, shift_reg_d;
    logic [N-1:0]   p_data_q, p_data_d;
    logic           p_valid_q, p_valid_d;
    logic [N-1:0]   w_word;
    logic           w_s_beat;

    assign s_ready  = (state_q == COLLECT);
    assign w_s_beat = s_valid && s_ready;
    assign w_word   = {s_data, shift_reg_q[N-1:1]};
    assign p_data   = p_data_q;
    assign p_valid  = p_valid_q;
    assign busy     = (count_q != '0) || (state_q == STALL);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        shift_reg_d = shift_reg_q;
        p_data_d    = p_data_q;
        p_valid_d   = p_valid_q;

        if (p_valid_q && p_ready) begin
            p_valid_d = 1'b0;
        end

        case (state_q)
            COLLECT: begin
                if (w_s_beat) begin
                    shift_reg_d = w_word;
                    if (count_q == LAST) begin
                        count_d = '0;
                        // Holding register free (or draining now): publish directly.
                        if (!p_valid_q || p_ready) begin
                            p_data_d  = w_word;
                            p_valid_d = 1'b1;
                        end else begin
                            state_d = STALL;
                        end
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            STALL: begin
                if (p_ready) begin
                    p_data_d  = shift_reg_q;
                    p_valid_d = 1'b1;
                    state_d   = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= COLLECT;
            count_q     <= '0;
            shift_reg_q <= '0;
            p_data_q    <= '0;
            p_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            shift_reg_q <= shift_reg_d;
            p_data_q    <= p_data_d;
            p_valid_q   <= p_valid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_s2p.sv
`default_nettype none
// ============================================================================
// Module   : tb_s2p
// Brief    : Directed and loopback bench for s2p (N=8 and N=5 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_s2p;

    logic       clk;
    logic       rstn;
    logic       s_valid [2];
    logic       s_data  [2];
    logic       s_ready [2];
    logic       p_valid [2];
    logic       p_ready [2];
    logic       busy    [2];
    logic [7:0] p_data8;
    logic [4:0] p_data5;

    int         n_checks;
    int         n_fail;
    int         rx [2];
    logic [7:0] sbq0 [$];
    logic [7:0] sbq1 [$];

    s2p #(.N(8)) u8 (
        .clk     (clk),
        .rstn    (rstn),
        .s_valid (s_valid[0]),
        .s_data  (s_data[0]),
        .s_ready (s_ready[0]),
        .p_data  (p_data8),
        .p_valid (p_valid[0]),
        .p_ready (p_ready[0]),
        .busy    (busy[0])
    );

    s2p #(.N(5)) u5 (
        .clk     (clk),
        .rstn    (rstn),
        .s_valid (s_valid[1]),
        .s_data  (s_data[1]),
        .s_ready (s_ready[1]),
        .p_data  (p_data5),
        .p_valid (p_valid[1]),
        .p_ready (p_ready[1]),
        .busy    (busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pdata(input int k);
        return (k == 0) ? p_data8 : {3'b000, p_data5};
    endfunction

    task automatic push(input int k, input logic [7:0] w);
        if (k == 0) sbq0.push_back(w);
        else        sbq1.push_back(w);
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? sbq0.size() : sbq1.size();
    endfunction

    // One clock: score parallel beats at the falling edge, return #1 after the rising edge.
    task automatic cycle();
        logic [7:0] exp;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (p_valid[k] && p_ready[k]) begin
                exp = 'x;
                if (k == 0 && sbq0.size() > 0) exp = sbq0.pop_front();
                if (k == 1 && sbq1.size() > 0) exp = sbq1.pop_front();
                rx[k]++;
                chk((k == 0) ? "sb_data_n8" : "sb_data_n5", 32'(pdata(k)), 32'(exp));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send8(input logic [7:0] w, input int nb);
        for (int i = 0; i < nb; i++) begin
            s_valid[0] = 1'b1;
            s_data[0]  = w[i];
            cycle();
        end
    endtask

    // Upstream parallel-to-serial model feeding instance k with n-bit words.
    task automatic loopback(input int k, input int n);
        int         sent;
        int         bi;
        int         cyc;
        int         rx0;
        bit         act;
        bit         beat;
        logic [7:0] w;
        logic [7:0] mask;
        sent = 0; bi = 0; cyc = 0; act = 0; w = '0;
        mask = 8'((1 << n) - 1);
        rx0  = rx[k];
        while ((sent < 200 || act || qsize(k) != 0) && cyc < 20000) begin
            if (!act && sent < 200 && $urandom_range(1) == 1) begin
                w = 8'($urandom) & mask;
                push(k, w);
                sent++;
                act = 1;
                bi  = 0;
            end
            s_valid[k] = act;
            s_data[k]  = act ? w[bi] : 1'b0;
            p_ready[k] = ($urandom_range(1) == 1);
            beat = act && s_ready[k];
            cycle();
            cyc++;
            if (beat) begin
                bi++;
                if (bi == n) act = 0;
            end
        end
        s_valid[k] = 1'b0;
        p_ready[k] = 1'b0;
        chk("loop_rx_count", 32'(rx[k] - rx0), 32'd200);
        chk("loop_queue_empty", 32'(qsize(k)), 32'd0);
    endtask

    initial begin
        logic [23:0] st;
        int          gaps;
        n_checks = 0;
        n_fail   = 0;
        rx[0] = 0; rx[1] = 0;
        rstn = 1'b0;
        for (int k = 0; k < 2; k++) begin
            s_valid[k] = 1'b0;
            s_data[k]  = 1'b0;
            p_ready[k] = 1'b0;
        end

        // Reset state
        cycle();
        cycle();
        chk("rst_s_ready", 32'(s_ready[0]), 32'd1);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_p_valid", 32'(p_valid[0]), 32'd0);
        chk("rst_p_data", 32'(p_data8), 32'd0);
        rstn = 1'b1;
        cycle();

        // Single word 0xA5, latency check
        p_ready[0] = 1'b1;
        push(0, 8'hA5);
        send8(8'hA5, 7);
        chk("a5_busy_mid", 32'(busy[0]), 32'd1);
        chk("a5_pv_early", 32'(p_valid[0]), 32'd0);
        s_data[0] = 1'b1;
        cycle();
        chk("a5_pv", 32'(p_valid[0]), 32'd1);
        chk("a5_pdata", 32'(p_data8), 32'hA5);
        s_valid[0] = 1'b0;
        cycle();
        chk("a5_pv_drop", 32'(p_valid[0]), 32'd0);

        // Continuous stream with p_ready=1
        st = {8'h01, 8'hFF, 8'h3C};
        push(0, 8'h3C); push(0, 8'hFF); push(0, 8'h01);
        for (int i = 0; i < 24; i++) begin
            chk("stream_s_ready", 32'(s_ready[0]), 32'd1);
            s_valid[0] = 1'b1;
            s_data[0]  = st[i];
            cycle();
            chk("stream_pv", 32'(p_valid[0]), 32'((i % 8) == 7));
        end
        s_valid[0] = 1'b0;
        cycle();

        // Backpressure into STALL
        p_ready[0] = 1'b0;
        push(0, 8'h12); push(0, 8'h34);
        send8(8'h12, 8);
        send8(8'h34, 8);
        s_valid[0] = 1'b0;
        chk("stall_s_ready", 32'(s_ready[0]), 32'd0);
        chk("stall_busy", 32'(busy[0]), 32'd1);
        chk("stall_pdata", 32'(p_data8), 32'h12);
        chk("stall_pv", 32'(p_valid[0]), 32'd1);
        cycle();
        chk("stall_hold", 32'(p_data8), 32'h12);
        p_ready[0] = 1'b1;
        cycle();
        p_ready[0] = 1'b0;
        chk("unstall_pdata", 32'(p_data8), 32'h34);
        chk("unstall_pv", 32'(p_valid[0]), 32'd1);
        chk("unstall_s_ready", 32'(s_ready[0]), 32'd1);
        chk("unstall_busy", 32'(busy[0]), 32'd0);
        p_ready[0] = 1'b1;
        cycle();
        chk("unstall_drained", 32'(p_valid[0]), 32'd0);

        // Gaps in s_valid
        st = {8'h00, 8'hC3, 8'h5A};
        push(0, 8'h5A); push(0, 8'hC3);
        for (int i = 0; i < 16; i++) begin
            gaps = 0;
            while (gaps < 3 && $urandom_range(1) == 0) begin
                s_valid[0] = 1'b0;
                cycle();
                if ((i % 8) != 0) chk("gap_busy", 32'(busy[0]), 32'd1);
                gaps++;
            end
            s_valid[0] = 1'b1;
            s_data[0]  = st[i];
            cycle();
        end
        s_valid[0] = 1'b0;
        cycle();
        cycle();

        // Reset mid-word
        send8(8'hFF, 4);
        s_valid[0] = 1'b0;
        rstn = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy[0]), 32'd0);
        chk("midrst_pv", 32'(p_valid[0]), 32'd0);
        cycle();
        rstn = 1'b1;
        cycle();
        chk("midrst_no_pulse", 32'(p_valid[0]), 32'd0);
        push(0, 8'h81);
        send8(8'h81, 8);
        s_valid[0] = 1'b0;
        chk("midrst_pdata", 32'(p_data8), 32'h81);
        cycle();
        cycle();
        chk("directed_queue_empty", 32'(qsize(0)), 32'd0);
        p_ready[0] = 1'b0;

        // Loopback against upstream serializer model
        loopback(0, 8);
        loopback(1, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
